// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single backing memory.
// Data side normally wins; a starvation counter forces a fetch grant, and stalled accesses time out.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [15:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_done_o,
    output logic [15:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [15:0] d_addr_i,
    input  logic [15:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_done_o,
    output logic [15:0] d_rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i
);

    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starveCnt_q, starveCnt_d;
    logic [CW-1:0]   cycleCnt_q, cycleCnt_d;
    logic [15:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            iDone_q, iDone_d;
    logic            dDone_q, dDone_d;
    logic            err_q, err_d;
    logic [15:0]     iRdata_q, iRdata_d;
    logic [15:0]     dRdata_q, dRdata_d;
    logic            iGnt, dGnt;
    logic            memReq, memWe;
    logic [15:0]     memAddr, memWdata;
    logic            accTimeout;

    // An ack in the last allowed cycle counts as success, so timeout needs ack low.
    assign accTimeout = (cycleCnt_q == CNT_LAST) && !mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dGnt) begin
                    state_d = D_ACC;
                end else if (iGnt) begin
                    state_d = I_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (mem_ack_i || accTimeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iGnt     = 1'b0;
        dGnt     = 1'b0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (d_req_i && (starveCnt_q < STARVE_MAX)) begin
                        dGnt = 1'b1;
                    end else if (i_req_i) begin
                        iGnt = 1'b1;
                    end
                end
                I_ACC, D_ACC: begin
                    memReq   = 1'b1;
                    memWe    = we_q;
                    memAddr  = addr_q;
                    memWdata = wdata_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        starveCnt_d = starveCnt_q;
        cycleCnt_d  = cycleCnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        iDone_d     = 1'b0;
        dDone_d     = 1'b0;
        err_d       = 1'b0;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;

        if (dGnt) begin
            addr_d     = d_addr_i;
            we_d       = d_we_i;
            wdata_d    = d_wdata_i;
            cycleCnt_d = '0;
        end else if (iGnt) begin
            addr_d     = i_addr_i;
            we_d       = 1'b0;
            wdata_d    = '0;
            cycleCnt_d = '0;
        end

        if (iGnt || (state_q == IDLE && !i_req_i)) begin
            starveCnt_d = '0;
        end else if (dGnt && i_req_i && (starveCnt_q < STARVE_MAX)) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end

        if (state_q != IDLE) begin
            cycleCnt_d = cycleCnt_q + 1'b1;
            if (mem_ack_i) begin
                if (state_q == I_ACC) begin
                    iDone_d  = 1'b1;
                    iRdata_d = mem_rdata_i;
                end else begin
                    dDone_d  = 1'b1;
                    dRdata_d = we_q ? 16'h0000 : mem_rdata_i;
                end
            end else if (accTimeout) begin
                err_d = 1'b1;
                if (state_q == I_ACC) begin
                    iDone_d  = 1'b1;
                    iRdata_d = 16'hFFFF;
                end else begin
                    dDone_d  = 1'b1;
                    dRdata_d = 16'hFFFF;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starveCnt_q <= '0;
            cycleCnt_q  <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            iDone_q     <= 1'b0;
            dDone_q     <= 1'b0;
            err_q       <= 1'b0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            cycleCnt_q  <= cycleCnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            iDone_q     <= iDone_d;
            dDone_q     <= dDone_d;
            err_q       <= err_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
        end
    end

    // Registered outputs are masked so every output reads zero during the reset cycle itself.
    assign i_gnt_o     = iGnt;
    assign d_gnt_o     = dGnt;
    assign i_done_o    = iDone_q && !rst_i;
    assign d_done_o    = dDone_q && !rst_i;
    assign err_o       = err_q && !rst_i;
    assign i_rdata_o   = rst_i ? 16'h0000 : iRdata_q;
    assign d_rdata_o   = rst_i ? 16'h0000 : dRdata_q;
    assign mem_req_o   = memReq;
    assign mem_we_o    = memWe;
    assign mem_addr_o  = memAddr;
    assign mem_wdata_o = memWdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checkCount = 0;
    int failCount  = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT(3),
        .TIMEOUT(15)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .i_req_i(i_req),
        .i_addr_i(i_addr),
        .i_gnt_o(i_gnt),
        .i_done_o(i_done),
        .i_rdata_o(i_rdata),
        .d_req_i(d_req),
        .d_we_i(d_we),
        .d_addr_i(d_addr),
        .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt),
        .d_done_o(d_done),
        .d_rdata_o(d_rdata),
        .err_o(err),
        .mem_req_o(mem_req),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ireq, input logic [15:0] iaddr,
                                 input logic dreq, input logic dwe,
                                 input logic [15:0] daddr, input logic [15:0] dwdata,
                                 input logic ack, input logic [15:0] rdata);
        i_req     = ireq;
        i_addr    = iaddr;
        d_req     = dreq;
        d_we      = dwe;
        d_addr    = daddr;
        d_wdata   = dwdata;
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Expected grant order with both sides requesting continuously (1 = fetch side).
    logic isI [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        nextCycle();
        nextCycle();
        checkOutput("reset d_gnt", d_gnt, 1'b0);
        checkOutput("reset i_gnt", i_gnt, 1'b0);
        checkOutput("reset mem_req", mem_req, 1'b0);
        checkOutput("reset d_rdata", d_rdata, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b0;
        nextCycle();
        checkOutput("idle mem_req", mem_req, 1'b0);
        checkOutput("idle done", {i_done, d_done, err}, 16'h0000);

        // single load, ack on second access cycle
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000);
        checkOutput("load d_gnt", d_gnt, 1'b1);
        checkOutput("load i_gnt", i_gnt, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("load mem_req T+1", mem_req, 1'b1);
        checkOutput("load mem_addr", mem_addr, 16'h0040);
        checkOutput("load mem_we", mem_we, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF);
        checkOutput("load mem_req T+2", mem_req, 1'b1);
        checkOutput("load early d_done", d_done, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("load d_done", d_done, 1'b1);
        checkOutput("load d_rdata", d_rdata, 16'hBEEF);
        checkOutput("load err", err, 1'b0);
        checkOutput("load mem_req T+3", mem_req, 1'b0);
        nextCycle();
        checkOutput("load d_done pulse", d_done, 1'b0);
        checkOutput("load d_rdata hold", d_rdata, 16'hBEEF);

        // store
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000);
        checkOutput("store d_gnt", d_gnt, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5555);
        checkOutput("store mem_req", mem_req, 1'b1);
        checkOutput("store mem_we", mem_we, 1'b1);
        checkOutput("store mem_wdata", mem_wdata, 16'h1234);
        checkOutput("store mem_addr", mem_addr, 16'h0010);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("store d_done", d_done, 1'b1);
        checkOutput("store d_rdata", d_rdata, 16'h0000);
        checkOutput("store idle mem_we", mem_we, 1'b0);
        checkOutput("store idle mem_wdata", mem_wdata, 16'h0000);
        nextCycle();

        // simultaneous requests and starvation order
        applyStimulus(1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            checkOutput("order i_gnt", i_gnt, isI[k]);
            checkOutput("order d_gnt", d_gnt, !isI[k]);
            nextCycle();
            applyStimulus(1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'(16'hA000 + k));
            checkOutput("order mem_addr", mem_addr, isI[k] ? 16'h1000 : 16'h2000);
            nextCycle();
            applyStimulus(k != 9, 16'h1000, k != 9, 1'b0, 16'h2000, 16'h0000, 1'b0, 16'h0000);
            checkOutput("order i_done", i_done, isI[k]);
            checkOutput("order d_done", d_done, !isI[k]);
            checkOutput("order rdata", isI[k] ? i_rdata : d_rdata, 16'(16'hA000 + k));
        end
        nextCycle();
        checkOutput("order quiet gnt", {i_gnt, d_gnt}, 16'h0000);

        // fetch timeout, ack never arrives
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("timeout i_gnt", i_gnt, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            nextCycle();
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
            checkOutput("timeout mem_req", mem_req, 1'b1);
            checkOutput("timeout early i_done", i_done, 1'b0);
        end
        nextCycle();
        checkOutput("timeout mem_req drop", mem_req, 1'b0);
        checkOutput("timeout i_done", i_done, 1'b1);
        checkOutput("timeout err", err, 1'b1);
        checkOutput("timeout i_rdata", i_rdata, 16'hFFFF);
        nextCycle();
        checkOutput("timeout i_done pulse", i_done, 1'b0);
        checkOutput("timeout err pulse", err, 1'b0);
        checkOutput("timeout i_rdata hold", i_rdata, 16'hFFFF);

        // ack in the last allowed cycle is a success; ack in IDLE is ignored
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000);
        checkOutput("edge d_gnt", d_gnt, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            nextCycle();
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        end
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1357);
        checkOutput("edge mem_req", mem_req, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h9999);
        checkOutput("edge d_done", d_done, 1'b1);
        checkOutput("edge err", err, 1'b0);
        checkOutput("edge d_rdata", d_rdata, 16'h1357);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("idle ack done", {i_done, d_done, err}, 16'h0000);
        checkOutput("idle ack d_rdata", d_rdata, 16'h1357);
        checkOutput("idle ack mem_req", mem_req, 1'b0);

        // reset while a data access is outstanding
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h0000);
        checkOutput("abort d_gnt", d_gnt, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("abort mem_req before", mem_req, 1'b1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("abort mem_req after", mem_req, 1'b0);
        checkOutput("abort d_done", d_done, 1'b0);
        nextCycle();
        checkOutput("abort d_done later", d_done, 1'b0);
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("abort i_gnt", i_gnt, 1'b1);
        checkOutput("abort no d_gnt", d_gnt, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4242);
        checkOutput("abort mem_addr", mem_addr, 16'h0200);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checkOutput("abort i_done", i_done, 1'b1);
        checkOutput("abort i_rdata", i_rdata, 16'h4242);
        checkOutput("abort err", err, 1'b0);

        nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
